// File: rtl/ldo_loop_ctrl.sv
// Digital LDO loop controller: comparator synchronizer, coarse slew / fine dither
// mode FSM, and a binary fine counter that carries into the coarse shift register.
module ldo_loop_ctrl #(
    parameter int FINE_BITS  = 6,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cmp,
    output logic                 up,
    output logic                 coarse_en,
    output logic                 carry_in_incr,
    output logic                 carry_in_decr,
    output logic [FINE_BITS-1:0] fine_code,
    output logic                 locked,
    output logic [1:0]           dbg_state
);

    localparam int REV_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [REV_W-1:0] REV_LAST = REV_W'(LOCK_CNT - 1);
    localparam logic [REV_W-1:0] REV_SAT  = REV_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(UNLOCK_CNT - 1);
    localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(UNLOCK_CNT);

    localparam logic [FINE_BITS-1:0] CODE_MID = FINE_BITS'(1) << (FINE_BITS - 1);
    localparam logic [FINE_BITS-1:0] CODE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2
    } state_t;

    state_t state;

    logic cmp_m;
    logic cmp_s;
    logic cmp_p;
    logic reversal;
    logic lock_hit;
    logic unlock_hit;

    logic [REV_W-1:0] rev_cnt;
    logic [REV_W-1:0] rev_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;

    assign dbg_state = state;

    assign reversal   = cmp_s ^ cmp_p;
    assign lock_hit   = reversal && (rev_cnt == REV_LAST);
    assign unlock_hit = !reversal && (run_cnt == RUN_LAST);

    // Saturating event counters; the FSM decides when they clear.
    always_comb begin
        rev_nxt = rev_cnt;
        run_nxt = run_cnt;
        if (reversal) begin
            if (rev_cnt != REV_SAT) rev_nxt = rev_cnt + REV_W'(1);
            run_nxt = '0;
        end else if (run_cnt != RUN_SAT) begin
            run_nxt = run_cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_m         <= 1'b0;
            cmp_s         <= 1'b0;
            cmp_p         <= 1'b0;
            state         <= IDLE;
            rev_cnt       <= '0;
            run_cnt       <= '0;
            up            <= 1'b0;
            coarse_en     <= 1'b0;
            carry_in_incr <= 1'b0;
            carry_in_decr <= 1'b0;
            locked        <= 1'b0;
            fine_code     <= CODE_MID;
        end else begin
            cmp_m <= cmp;
            cmp_s <= cmp_m;
            cmp_p <= cmp_s;

            // Carries default low so every pulse is exactly one cycle wide.
            carry_in_incr <= 1'b0;
            carry_in_decr <= 1'b0;

            if (!en) begin
                state     <= IDLE;
                rev_cnt   <= '0;
                run_cnt   <= '0;
                up        <= 1'b0;
                coarse_en <= 1'b0;
                locked    <= 1'b0;
                fine_code <= CODE_MID;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= COARSE;
                        rev_cnt   <= '0;
                        run_cnt   <= '0;
                        up        <= 1'b0;
                        coarse_en <= 1'b0;
                        locked    <= 1'b0;
                        fine_code <= CODE_MID;
                    end
                    COARSE: begin
                        up <= cmp_s;
                        if (lock_hit) begin
                            state     <= FINE;
                            rev_cnt   <= '0;
                            run_cnt   <= '0;
                            coarse_en <= 1'b0;
                            locked    <= 1'b1;
                            fine_code <= CODE_MID;
                        end else begin
                            rev_cnt   <= rev_nxt;
                            run_cnt   <= run_nxt;
                            coarse_en <= 1'b1;
                        end
                    end
                    FINE: begin
                        up        <= cmp_s;
                        coarse_en <= 1'b0;
                        if (unlock_hit) begin
                            // Drift detected: recentre and let the coarse array track again.
                            state     <= COARSE;
                            rev_cnt   <= '0;
                            run_cnt   <= '0;
                            locked    <= 1'b0;
                            fine_code <= CODE_MID;
                        end else begin
                            rev_cnt <= rev_nxt;
                            run_cnt <= run_nxt;
                            if (cmp_s) begin
                                if (fine_code == CODE_MAX) begin
                                    fine_code     <= '0;
                                    carry_in_incr <= 1'b1;
                                end else begin
                                    fine_code <= fine_code + FINE_BITS'(1);
                                end
                            end else begin
                                if (fine_code == '0) begin
                                    fine_code     <= CODE_MAX;
                                    carry_in_decr <= 1'b1;
                                end else begin
                                    fine_code <= fine_code - FINE_BITS'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ldo_loop_ctrl.sv
// Randomised bench for ldo_loop_ctrl: a behavioural loop model predicts every
// cycle's outputs into a queue, and a negedge monitor compares the DUT against it.
module tb_ldo_loop_ctrl;

    localparam int FB   = 6;
    localparam int LC   = 4;
    localparam int UC   = 8;
    localparam int MID  = 32;
    localparam int MAX  = 63;
    localparam int W    = FB + 7;
    localparam logic [W-1:0] RESET_VEC = {2'b00, 5'b00000, 6'd32};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          cmp = 1'b0;
    logic          up;
    logic          coarse_en;
    logic          carry_in_incr;
    logic          carry_in_decr;
    logic [FB-1:0] fine_code;
    logic          locked;
    logic [1:0]    dbg_state;

    ldo_loop_ctrl #(
        .FINE_BITS (FB),
        .LOCK_CNT  (LC),
        .UNLOCK_CNT(UC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cmp          (cmp),
        .up           (up),
        .coarse_en    (coarse_en),
        .carry_in_incr(carry_in_incr),
        .carry_in_decr(carry_in_decr),
        .fine_code    (fine_code),
        .locked       (locked),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    // Behavioural model: mode 0 idle, 1 coarse, 2 fine.
    int m_mode, m_rev, m_run, m_code;
    bit m_up, m_cen, m_ci, m_cd, m_lock;
    int hist[$];
    int n_ci = 0, n_cd = 0, n_unlock = 0, n_lock = 0;

    function automatic void model_reset();
        m_mode = 0; m_rev = 0; m_run = 0; m_code = MID;
        m_up = 0; m_cen = 0; m_ci = 0; m_cd = 0; m_lock = 0;
        hist.delete();
        repeat (4) hist.push_back(0);
    endfunction

    function automatic logic [W-1:0] model_vec();
        return {2'(m_mode), m_up, m_cen, m_ci, m_cd, m_lock, 6'(m_code)};
    endfunction

    function automatic void count_samples(input bit rev);
        if (rev) begin
            m_rev = (m_rev + 1 > LC) ? LC : m_rev + 1;
            m_run = 0;
        end else begin
            m_run = (m_run + 1 > UC) ? UC : m_run + 1;
        end
    endfunction

    function automatic void model_step(input bit e, input bit c);
        int s, p, nxt;
        bit rev;
        hist.push_front(int'(c));
        void'(hist.pop_back());
        s = hist[2];
        p = hist[3];
        rev = (s != p);
        m_ci = 0;
        m_cd = 0;
        if (!e) begin
            m_mode = 0; m_rev = 0; m_run = 0; m_code = MID;
            m_up = 0; m_cen = 0; m_lock = 0;
            return;
        end
        case (m_mode)
            0: begin
                m_mode = 1; m_rev = 0; m_run = 0;
            end
            1: begin
                m_up = s[0];
                if (rev && m_rev + 1 >= LC) begin
                    m_mode = 2; m_rev = 0; m_run = 0;
                    m_cen = 0; m_lock = 1; m_code = MID;
                    n_lock++;
                end else begin
                    count_samples(rev);
                    m_cen = 1;
                end
            end
            default: begin
                m_up = s[0];
                m_cen = 0;
                if (!rev && m_run + 1 >= UC) begin
                    m_mode = 1; m_rev = 0; m_run = 0;
                    m_lock = 0; m_code = MID;
                    n_unlock++;
                end else begin
                    count_samples(rev);
                    nxt = m_code + ((s != 0) ? 1 : -1);
                    m_ci = (nxt > MAX);
                    m_cd = (nxt < 0);
                    m_code = (nxt + MAX + 1) % (MAX + 1);
                    if (m_ci) n_ci++;
                    if (m_cd) n_cd++;
                end
            end
        endcase
    endfunction

    // Would the next edge produce a carry if en stayed high?
    function automatic bit carry_next();
        int s, p;
        s = hist[1];
        p = hist[2];
        if (m_mode != 2) return 0;
        if (s == p && m_run + 1 >= UC) return 0;
        return (s != 0 && m_code == MAX) || (s == 0 && m_code == 0);
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(en, cmp);
            exp_q.push_back(model_vec());
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got st=%0d up=%b cen=%b ci=%b cd=%b lk=%b code=%0d, expected st=%0d up=%b cen=%b ci=%b cd=%b lk=%b code=%0d",
                     name, $time, act[12:11], act[10], act[9], act[8], act[7], act[6], act[5:0],
                     exp[12:11], exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    // Monitor: one prediction per rising edge, consumed on the following falling edge.
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty @%0t: got no prediction, required one", $time);
            end else begin
                exp = exp_q.pop_front();
                check("cycle_outputs",
                      {dbg_state, up, coarse_en, carry_in_incr, carry_in_decr, locked, fine_code}, exp);
            end
        end
    end

    task automatic drive(input bit e, input bit c);
        @(negedge clk);
        #1;
        en = e;
        cmp = c;
    endtask

    task automatic do_reset(input bit aligned);
        if (!aligned) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset",
              {dbg_state, up, coarse_en, carry_in_incr, carry_in_decr, locked, fine_code}, RESET_VEC);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs of five samples in one direction broken by a single reversal keep the
    // loop in FINE while the code walks steadily. stop_kind 1 drops en on the
    // edge a carry is due; stop_kind 2 stops once the code reaches 0x2A.
    task automatic ramp(input bit dir, input int n, input int stop_kind, output bit hit);
        int run_len;
        bit c, e;
        run_len = 0;
        hit = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (stop_kind == 2 && m_mode == 2 && m_code == 42) begin
                hit = 1;
                break;
            end
            e = 1;
            if (run_len == 5) begin
                c = !dir;
                run_len = 0;
            end else begin
                c = dir;
                run_len++;
            end
            if (stop_kind == 1 && !hit && carry_next()) begin
                e = 0;
                hit = 1;
            end
            en = e;
            cmp = c;
        end
    endtask

    task automatic coverage(input string name, input int seen);
        tests++;
        if (seen == 0) begin
            fails++;
            $display("FAIL coverage_%s: got 0 occurrences, required at least 1", name);
        end
    endtask

    initial begin
        bit hit_drop, hit_42, c;
        int len;
        hit_drop = 0;
        hit_42 = 0;

        // Power-on reset, then idle with en low.
        @(negedge clk);
        #1;
        check("reset_values",
              {dbg_state, up, coarse_en, carry_in_incr, carry_in_decr, locked, fine_code}, RESET_VEC);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'($urandom_range(0, 1)));

        // Coarse slew with the comparator stuck high.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);

        // Toggle every cycle to lock.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'(i & 1));

        // Walk up through a carry-in-incr, then down through a carry-in-decr.
        ramp(1'b1, 120, 0, hit_drop);
        ramp(1'b0, 160, 0, hit_drop);

        // Hold the comparator to force an unlock.
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b1);

        // Relock, then drop en exactly where a carry would fire.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'(i & 1));
        ramp(1'b1, 300, 1, hit_drop);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);

        // Relock, walk to 0x2A and reset asynchronously mid-FINE.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'(i & 1));
        ramp(1'b1, 300, 2, hit_42);
        do_reset(hit_42);

        // Random comparator runs with occasional enable drops and one more reset.
        for (int blk = 0; blk < 300; blk++) begin
            c = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++)
                drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, c);
            if (blk == 150) do_reset(1'b0);
        end

        repeat (3) @(negedge clk);
        #1;
        coverage("lock", n_lock);
        coverage("carry_incr", n_ci);
        coverage("carry_decr", n_cd);
        coverage("unlock", n_unlock);
        coverage("drop_on_carry", int'(hit_drop));
        coverage("reset_at_2a", int'(hit_42));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ldo_loop_ctrl.md
# ldo_loop_ctrl

Loop controller for the digital LDO that sits directly upstream of the coarse pass-device shift register and drives its `up`, `coarse_en`, `carry_in_incr` and `carry_in_decr` inputs. It samples the asynchronous comparator, slews the coarse array until the loop dithers, then hands over to a binary fine counter. The fine counter emits single-cycle carry pulses into the coarse stage on overflow or underflow. A mode FSM falls back to coarse tracking when the output drifts.

## Interface
- `FINE_BITS`, default 6: width of the fine code; one coarse cell equals 2^FINE_BITS fine LSBs.
- `LOCK_CNT`, default 4: number of comparator reversals in COARSE needed to enter FINE; must be ≥1.
- `UNLOCK_CNT`, default 8: number of consecutive same-direction samples in FINE that forces a return to COARSE; must be ≥2.

- `clk`, input, 1: loop clock.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `en`, input, 1: loop enable; synchronous level.
- `cmp`, input, 1: comparator output, asynchronous. 1 means Vout < Vref (more current needed).
- `up`, output, 1: direction to the coarse stage; registered.
- `coarse_en`, output, 1: coarse shift enable; registered.
- `carry_in_incr`, output, 1: one-cycle pulse that adds one coarse cell; registered.
- `carry_in_decr`, output, 1: one-cycle pulse that removes one coarse cell; registered.
- `fine_code`, output, FINE_BITS: fine pass-device code; registered.
- `locked`, output, 1: high while in FINE; registered.

## Operation
- **Synchronizer.** `cmp` passes through a 2-flop synchronizer to produce `cmp_s`. A third flop holds `cmp_p`, the previous value of `cmp_s`.
  - A reversal is `cmp_s != cmp_p`.
  - A same-direction sample is `cmp_s == cmp_p`.
- **Counters.**
  - `rev_cnt` counts reversals and saturates at LOCK_CNT.
  - `run_cnt` counts consecutive same-direction samples. It clears on a reversal and saturates at UNLOCK_CNT.
  - Both counters clear on every state change.
- **FSM states:** IDLE, COARSE, FINE.
- **IDLE.**
  - Outputs: `coarse_en`=0, carries=0, `up`=0, `locked`=0, `fine_code`=2^(FINE_BITS-1).
  - `en`=1 moves the FSM to COARSE.
- **COARSE.**
  - Every cycle: `up`←`cmp_s`, `coarse_en`←1, carries held 0, `fine_code` held at mid.
  - The FSM moves to FINE when `rev_cnt` would reach LOCK_CNT on the current edge. On that edge: `coarse_en`←0, `locked`←1, `fine_code`←mid.
- **FINE.** Every cycle: `up`←`cmp_s`, `coarse_en`←0.
  - `cmp_s`=1 and `fine_code`<max: increment `fine_code`.
  - `cmp_s`=1 and `fine_code`=max: wrap `fine_code` to 0 and pulse `carry_in_incr` for 1 cycle.
  - `cmp_s`=0 and `fine_code`>0: decrement `fine_code`.
  - `cmp_s`=0 and `fine_code`=0: wrap `fine_code` to max and pulse `carry_in_decr` for 1 cycle.
  - The two carries are never high together.
  - Carry pulses may occur on consecutive cycles only if the code wraps repeatedly. That is impossible for FINE_BITS≥1, so a minimum of 2^FINE_BITS cycles separates carries in the same direction.
- **Unlock.** In FINE, when `run_cnt` would reach UNLOCK_CNT on the current edge:
  - State←COARSE, `locked`←0, `fine_code`←mid.
  - No fine update and no carry on that edge.
  - `coarse_en` rises on the following edge.
- **Enable drop.** `en`=0 in any state moves the FSM to IDLE on the next edge. IDLE output values appear on that same edge, and any pending carry is dropped.
- **Arithmetic.** `fine_code` is unsigned modulo 2^FINE_BITS. Counters are sized to clog2(max+1) bits.

## Timing
- **Reset** (async assert, sync deassert is external). Values on reset:
  - State=IDLE, `up`=0, `coarse_en`=0, carries=0, `locked`=0, `fine_code`=2^(FINE_BITS-1).
  - Synchronizer and `cmp_p` flops = 0.
  - Counters = 0.
- **Reset mid-operation.** Outputs change immediately, without waiting for a clock edge, including during a carry pulse.
- **Comparator latency.** A `cmp` change reaches `cmp_s` after 2 edges and `up`/`fine_code` after 3 edges.
- **Enable latency.** `en` rise to the first `coarse_en`=1 takes 2 edges (IDLE→COARSE, then the first COARSE output).
- **Outputs.** All outputs change only on the `clk` rising edge. Carries are exactly 1 cycle wide.
- **Simultaneous events.** `en`=0 has priority over lock, unlock and carry. Unlock has priority over a fine wrap on the same edge.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-FINE with `fine_code`=0x2A → all outputs reach their reset values without a clock edge; `fine_code`=0x20.
- **Coarse slew.** `en`=1, `cmp` held 1 → `coarse_en`=1 and `up`=1 every cycle from edge 2; `locked` stays 0.
- **Lock.** Toggle `cmp` every cycle → `locked`=1 and `coarse_en`=0 on the edge of the 4th reversal; `fine_code`=32.
- **Carry up.** In FINE, hold `cmp`=1 from `fine_code`=63 → `fine_code`=0 with `carry_in_incr`=1 for exactly 1 cycle.
  - Same for carry down: hold `cmp`=0 from `fine_code`=0 → `fine_code`=63 with `carry_in_decr`=1 for exactly 1 cycle.
- **Unlock.** In FINE, hold `cmp`=1 for 8 consecutive samples → `locked`=0, `fine_code`=32, `coarse_en`=1 on the next edge; no carry emitted.
- **Enable drop.** Drop `en` on the same edge that a carry would fire → FSM goes to IDLE, no carry pulse, `fine_code`=32.
